// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register-file geometry, grant encoding, result record.
// Optional WB_STALL_CNT_EN build adds an ALU stall counter; nothing here depends on it.
package wb_arbiter_pkg;

    localparam int          REG_AW   = 6;
    localparam int          XLEN     = 32;
    localparam logic [5:0]  ZERO_REG = 6'd0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_FIFO = 2'd1,
        GNT_MEM  = 2'd2,
        GNT_ALU  = 2'd3
    } gnt_e;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between execution units (master) and the arbiter (slave).
// WB_STALL_CNT_EN adds the alu_stall_cnt observation signal.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_wa;
    logic [XLEN-1:0]   alu_wd;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_wa;
    logic [XLEN-1:0]   mem_wd;
    logic              fpu_valid;
    logic [REG_AW-1:0] fpu_wa;
    logic [XLEN-1:0]   fpu_wd;
    logic              fpu_almost_full;
    logic              fpu_ovf;
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
`ifdef WB_STALL_CNT_EN
    logic [31:0]       alu_stall_cnt;
`endif

    modport master (
        output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
               fpu_valid, fpu_wa, fpu_wd,
        input  alu_ready, mem_ready, fpu_almost_full, fpu_ovf, we, wa, wd
`ifdef WB_STALL_CNT_EN
        , input alu_stall_cnt
`endif
    );

    modport slave (
        input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
               fpu_valid, fpu_wa, fpu_wd,
        output alu_ready, mem_ready, fpu_almost_full, fpu_ovf, we, wa, wd
`ifdef WB_STALL_CNT_EN
        , output alu_stall_cnt
`endif
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO for FPU results; head visible combinationally, pop/push take effect at the edge.
// No back-pressure: a push into a full FIFO without a same-cycle pop is dropped and latches ovf_o.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      push_i,
    input  wb_req_t                   push_dat_i,
    input  logic                      pop_i,
    output wb_req_t                   head_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      almost_full_o,
    output logic                      ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q;
    logic            full;
    logic            push_ok;

    assign full    = (count_q == CW'(DEPTH));
    // Popping frees the slot the push needs, so a full FIFO still accepts then.
    assign push_ok = push_i && (!full || pop_i);
    assign count_d = count_q + CW'(push_ok) - CW'(pop_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (push_i && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_o        = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= CW'(DEPTH - 1));
    assign ovf_o         = ovf_q;

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU, load and FPU results onto one registered register-file write port (1-cycle latency).
// ALU/mem stall via combinational ready; FPU is buffered; WB_STALL_CNT_EN adds alu_stall_cnt.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int URGENT_LVL = 3
) (
    input  logic          clk,
    input  logic          rstn,
    wb_arbiter_if.slave   bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_req_t           fifo_head;
    wb_req_t           fpu_req;
    wb_req_t           sel;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_af;
    logic              fifo_ovf;
    logic              fifo_nonempty;
    logic              urgent;
    gnt_e              gnt;
    logic              we_q;
    logic [REG_AW-1:0] wa_q;
    logic [XLEN-1:0]   wd_q;

    assign fpu_req = '{wa: bus.fpu_wa, wd: bus.fpu_wd};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk           (clk),
        .rstn          (rstn),
        .push_i        (bus.fpu_valid),
        .push_dat_i    (fpu_req),
        .pop_i         (gnt == GNT_FIFO),
        .head_o        (fifo_head),
        .count_o       (fifo_cnt),
        .almost_full_o (fifo_af),
        .ovf_o         (fifo_ovf)
    );

    assign fifo_nonempty = (fifo_cnt != '0);
    assign urgent        = fifo_nonempty && (fifo_cnt >= CW'(URGENT_LVL));

    always_comb begin
        gnt = GNT_NONE;
        sel = fifo_head;
        if (urgent) begin
            gnt = GNT_FIFO;
        end else if (bus.mem_valid) begin
            gnt = GNT_MEM;
            sel = '{wa: bus.mem_wa, wd: bus.mem_wd};
        end else if (fifo_nonempty) begin
            gnt = GNT_FIFO;
        end else if (bus.alu_valid) begin
            gnt = GNT_ALU;
            sel = '{wa: bus.alu_wa, wd: bus.alu_wd};
        end
    end

    assign bus.mem_ready       = (gnt == GNT_MEM);
    assign bus.alu_ready       = (gnt == GNT_ALU);
    assign bus.fpu_almost_full = fifo_af;
    assign bus.fpu_ovf         = fifo_ovf;

    // Writes to integer x0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= (gnt != GNT_NONE) && (sel.wa != ZERO_REG);
            if (gnt != GNT_NONE) begin
                wa_q <= sel.wa;
                wd_q <= sel.wd;
            end
        end
    end

    assign bus.we = we_q;
    assign bus.wa = wa_q;
    assign bus.wd = wd_q;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else if (bus.alu_valid && !bus.alu_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.alu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: table of per-cycle vectors plus overflow and reset-mid-drain sequences.
// A second instance with urgency disabled is used to reach FIFO overflow.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    wb_arbiter_if bus1 ();
    wb_arbiter_if bus2 ();

    wb_arbiter #(.FIFO_DEPTH(4), .URGENT_LVL(3)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );

    wb_arbiter #(.FIFO_DEPTH(4), .URGENT_LVL(5)) u_dut_ovf (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic        alu_v;
        logic [5:0]  alu_wa;
        logic [31:0] alu_wd;
        logic        mem_v;
        logic [5:0]  mem_wa;
        logic [31:0] mem_wd;
        logic        fpu_v;
        logic [5:0]  fpu_wa;
        logic [31:0] fpu_wd;
        logic        e_alu_rdy;
        logic        e_mem_rdy;
        logic        e_we;
        logic [5:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_af;
        logic        e_ovf;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive1(input vec_t v);
        bus1.alu_valid = v.alu_v; bus1.alu_wa = v.alu_wa; bus1.alu_wd = v.alu_wd;
        bus1.mem_valid = v.mem_v; bus1.mem_wa = v.mem_wa; bus1.mem_wd = v.mem_wd;
        bus1.fpu_valid = v.fpu_v; bus1.fpu_wa = v.fpu_wa; bus1.fpu_wd = v.fpu_wd;
    endtask

    task automatic idle2();
        bus2.alu_valid = 1'b0; bus2.alu_wa = '0; bus2.alu_wd = '0;
        bus2.mem_valid = 1'b0; bus2.mem_wa = '0; bus2.mem_wd = '0;
        bus2.fpu_valid = 1'b0; bus2.fpu_wa = '0; bus2.fpu_wd = '0;
    endtask

    initial begin
        vec_t idle;
        checks = 0;
        errors = 0;
        idle   = '0;
        //               alu v/wa/wd             mem v/wa/wd             fpu v/wa/wd                ar    mr    we    wa     wd             af    ovf
        vecs[0]  = '{1'b1, 6'd5, 32'h1234,  1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b1, 1'b0, 1'b1, 6'd5,  32'h1234, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 6'd8, 32'hBB,    1'b1, 6'd7, 32'hAA, 1'b0, 6'd0,  32'h0,     1'b0, 1'b1, 1'b1, 6'd7,  32'hAA,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 6'd8, 32'hBB,    1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b1, 1'b0, 1'b1, 6'd8,  32'hBB,   1'b0, 1'b0};
        vecs[3]  = '{1'b0, 6'd0, 32'h0,     1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b0, 6'd8,  32'hBB,   1'b0, 1'b0};
        vecs[4]  = '{1'b1, 6'd0, 32'hFFFF,  1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b1, 1'b0, 1'b0, 6'd0,  32'hFFFF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 6'd0, 32'h0,     1'b1, 6'd10, 32'h1, 1'b1, 6'd33, 32'hF33,   1'b0, 1'b1, 1'b1, 6'd10, 32'h1,    1'b0, 1'b0};
        vecs[6]  = '{1'b0, 6'd0, 32'h0,     1'b1, 6'd10, 32'h2, 1'b1, 6'd34, 32'hF34,   1'b0, 1'b1, 1'b1, 6'd10, 32'h2,    1'b0, 1'b0};
        vecs[7]  = '{1'b0, 6'd0, 32'h0,     1'b1, 6'd10, 32'h3, 1'b1, 6'd35, 32'hF35,   1'b0, 1'b1, 1'b1, 6'd10, 32'h3,    1'b1, 1'b0};
        vecs[8]  = '{1'b0, 6'd0, 32'h0,     1'b1, 6'd10, 32'h4, 1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b1, 6'd33, 32'hF33,  1'b0, 1'b0};
        vecs[9]  = '{1'b0, 6'd0, 32'h0,     1'b1, 6'd10, 32'h4, 1'b0, 6'd0,  32'h0,     1'b0, 1'b1, 1'b1, 6'd10, 32'h4,    1'b0, 1'b0};
        vecs[10] = '{1'b0, 6'd0, 32'h0,     1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b1, 6'd34, 32'hF34,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 6'd0, 32'h0,     1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b1, 6'd35, 32'hF35,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 6'd0, 32'h0,     1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b0, 6'd35, 32'hF35,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 6'd0, 32'h0,     1'b0, 6'd0, 32'h0,  1'b1, 6'd40, 32'h40,    1'b0, 1'b0, 1'b0, 6'd35, 32'hF35,  1'b0, 1'b0};
        vecs[14] = '{1'b0, 6'd0, 32'h0,     1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b1, 6'd40, 32'h40,   1'b0, 1'b0};
        vecs[15] = '{1'b1, 6'd9, 32'h99,    1'b0, 6'd0, 32'h0,  1'b1, 6'd41, 32'h41,    1'b1, 1'b0, 1'b1, 6'd9,  32'h99,   1'b0, 1'b0};
        vecs[16] = '{1'b1, 6'd9, 32'h98,    1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b1, 6'd41, 32'h41,   1'b0, 1'b0};
        vecs[17] = '{1'b1, 6'd9, 32'h98,    1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b1, 1'b0, 1'b1, 6'd9,  32'h98,   1'b0, 1'b0};
        vecs[18] = '{1'b0, 6'd0, 32'h0,     1'b0, 6'd0, 32'h0,  1'b0, 6'd0,  32'h0,     1'b0, 1'b0, 1'b0, 6'd9,  32'h98,   1'b0, 1'b0};

        // Reset state
        rstn = 1'b0;
        drive1(idle);
        idle2();
        #12;
        chk("rst_we", 32'(bus1.we), 32'd0);
        chk("rst_wa", 32'(bus1.wa), 32'd0);
        chk("rst_wd", bus1.wd, 32'd0);
        chk("rst_af", 32'(bus1.fpu_almost_full), 32'd0);
        chk("rst_ovf", 32'(bus1.fpu_ovf), 32'd0);
        chk("rst_alu_rdy", 32'(bus1.alu_ready), 32'd0);
        chk("rst_mem_rdy", 32'(bus1.mem_ready), 32'd0);
`ifdef WB_STALL_CNT_EN
        chk("rst_stall_cnt", bus1.alu_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive1(vecs[i]);
            #1;
            chk($sformatf("v%0d_alu_rdy", i), 32'(bus1.alu_ready), 32'(vecs[i].e_alu_rdy));
            chk($sformatf("v%0d_mem_rdy", i), 32'(bus1.mem_ready), 32'(vecs[i].e_mem_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(bus1.we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_wa", i), 32'(bus1.wa), 32'(vecs[i].e_wa));
            chk($sformatf("v%0d_wd", i), bus1.wd, vecs[i].e_wd);
            chk($sformatf("v%0d_af", i), 32'(bus1.fpu_almost_full), 32'(vecs[i].e_af));
            chk($sformatf("v%0d_ovf", i), 32'(bus1.fpu_ovf), 32'(vecs[i].e_ovf));
        end
`ifdef WB_STALL_CNT_EN
        chk("stall_cnt", bus1.alu_stall_cnt, 32'd2);
`endif
        @(negedge clk);
        drive1(idle);

        // Overflow: mem always wins on the non-urgent instance, fifth push is dropped
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.mem_valid = 1'b1; bus2.mem_wa = 6'd11; bus2.mem_wd = 32'(100 + i);
            bus2.alu_valid = 1'b1; bus2.alu_wa = 6'd12; bus2.alu_wd = 32'h0;
            bus2.fpu_valid = 1'b1; bus2.fpu_wa = 6'(50 + i); bus2.fpu_wd = 32'(500 + i);
            #1;
            chk($sformatf("ovf%0d_mem_rdy", i), 32'(bus2.mem_ready), 32'd1);
            chk($sformatf("ovf%0d_alu_rdy", i), 32'(bus2.alu_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("ovf%0d_wd", i), bus2.wd, 32'(100 + i));
            chk($sformatf("ovf%0d_af", i), 32'(bus2.fpu_almost_full), (i >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("ovf%0d_flag", i), 32'(bus2.fpu_ovf), (i == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        idle2();
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("drain%0d_we", j), 32'(bus2.we), 32'd1);
            chk($sformatf("drain%0d_wa", j), 32'(bus2.wa), 32'(50 + j));
            chk($sformatf("drain%0d_wd", j), bus2.wd, 32'(500 + j));
            chk($sformatf("drain%0d_ovf", j), 32'(bus2.fpu_ovf), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("drain_end_we", 32'(bus2.we), 32'd0);

        // Reset mid-drain: two FPU results buffered while mem holds the port
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus1.mem_valid = 1'b1; bus1.mem_wa = 6'd13; bus1.mem_wd = 32'(700 + i);
            bus1.fpu_valid = 1'b1; bus1.fpu_wa = 6'(60 + i); bus1.fpu_wd = 32'(600 + i);
            @(posedge clk);
            #1;
        end
        chk("pre_rst_we", 32'(bus1.we), 32'd1);
        drive1(idle);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rst_we", 32'(bus1.we), 32'd0);
        chk("async_rst_wa", 32'(bus1.wa), 32'd0);
        chk("rst_clears_ovf", 32'(bus2.fpu_ovf), 32'd0);
`ifdef WB_STALL_CNT_EN
        chk("mid_rst_stall_cnt", bus1.alu_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_we", k), 32'(bus1.we), 32'd0);
        end
        chk("post_rst_wa", 32'(bus1.wa), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that merges results from the ALU, load unit and FPU into the single write port (`we`/`wa`/`wd`) of the 64-entry register file (0–31 integer, 32–63 float). It sits directly upstream of the register file. It applies fixed priority with an urgency override, buffers non-stallable FPU results in a 4-deep FIFO, discards writes to integer register 0, and drives a registered write port one cycle after acceptance.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: FPU result FIFO entries, power of two, ≥2.
- `URGENT_LVL`, 3: FIFO occupancy at or above which the FIFO head takes top priority.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_wa`  in  6  ALU destination.
- `alu_wd`  in  32  ALU data.
- `mem_valid`, `mem_ready`, `mem_wa`, `mem_wd`: same as ALU, for the load unit.
- `fpu_valid`  in  1  FPU result; no back-pressure, pushed into the FIFO.
- `fpu_wa`  in  6  FPU destination.
- `fpu_wd`  in  32  FPU data.
- `fpu_almost_full`  out  1  FIFO count ≥ `FIFO_DEPTH`-1; the FPU issue stage stalls on it.
- `fpu_ovf`  out  1  sticky: a push was dropped.
- `we`  out  1  register file write enable, registered.
- `wa`  out  6  register file write address, registered.
- `wd`  out  32  register file write data, registered.
- `alu_stall_cnt`  out  32  present only with `WB_STALL_CNT_EN`.

## Operation
- Candidates each cycle: FIFO head (count>0), mem (`mem_valid`), alu (`alu_valid`).
- Grant order:
  - If count ≥ `URGENT_LVL`: FIFO > mem > alu.
  - Otherwise: mem > FIFO > alu.
- Exactly one candidate is granted per cycle, or none.
- Ready outputs are combinational: `mem_ready` = grant to mem; `alu_ready` = grant to alu. A source is consumed when valid & granted.
- FIFO pop = grant to the FIFO.
- FIFO push = `fpu_valid`. A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and `fpu_ovf` is set. It is cleared only by reset.
- Push and pop in the same cycle leave the count unchanged. A push into an empty FIFO is not eligible for grant until the next cycle.
- Zero-register rule: a granted entry with wa == 6'd0 is consumed, but the output stage loads `we`=0.
- Output stage, on each edge:
  - `we` ← granted & (granted wa ≠ 0).
  - `wa`/`wd` ← granted wa/wd when a grant occurs; otherwise they hold their previous value.
- Pointers wrap modulo `FIFO_DEPTH`. Count is log2(`FIFO_DEPTH`)+1 bits.

## Timing
- Reset values: `we`=0, `wa`=0, `wd`=0, FIFO empty (pointers 0, count 0), `fpu_ovf`=0, `fpu_almost_full`=0, `alu_stall_cnt`=0. Ready outputs follow the empty state combinationally.
- Latency: a result accepted in cycle N appears on `we`/`wa`/`wd` in cycle N+1. The register file commits it at the end of N+1, and its write-through bypass serves same-cycle reads.
- FPU latency: push in cycle N → earliest pop in N+1 → write port in N+2.
- Throughput: one write per cycle.
- Reset asserted mid-operation: all buffered FIFO entries are lost, and `we` deasserts immediately (asynchronous).

## Configuration
- `WB_STALL_CNT_EN` defined: `alu_stall_cnt` increments by 1 each cycle with `alu_valid` & !`alu_ready`. It saturates at 32'hFFFF_FFFF and is reset to 0.
- `WB_STALL_CNT_EN` undefined: the port and counter are absent. No other behaviour changes.

## Structure
- Shared package holds:
  - `REG_AW`=6, `XLEN`=32, `ZERO_REG`=6'd0.
  - Grant source encoding: `GNT_NONE`, `GNT_FIFO`, `GNT_MEM`, `GNT_ALU`.
- One sub-module: `wb_fifo` (sync FIFO: push/pop, head, count, full, almost_full, overflow flag). Arbitration and the output stage stay in `wb_arbiter`.

## Test plan
- ALU only: alu_valid=1, alu_wa=5, alu_wd=32'h1234 in cycle 0 → `alu_ready`=1 in cycle 0; `we`=1, `wa`=5, `wd`=32'h1234 in cycle 1.
- Conflict: mem(wa=7, 32'hAA) and alu(wa=8, 32'hBB) valid together, FIFO empty → mem written in cycle 1, alu stalled one cycle, alu written in cycle 2.
- Urgency: push 3 FPU results (wa=33,34,35) on consecutive cycles while mem stays valid → once count reaches 3, `fpu_almost_full`=1 and the FIFO head wins over mem. FPU writes drain in order 33, 34, 35.
- Overflow: hold mem and alu valid (mem continuously granted) and push 5 FPU results → the 5th push is dropped and `fpu_ovf`=1 stays set. The 4 buffered results drain correctly afterwards.
- Zero register: alu_wa=0, alu_wd=32'hFFFF → `alu_ready`=1, and `we` stays 0 next cycle.
- Reset mid-drain: rstn low with FIFO count 2 and `we`=1 → `we`=0 immediately. After release, no stale FPU writes appear; with `WB_STALL_CNT_EN`, the counter reads 0.
